// File: rtl/ccd_pkg.sv
// Shared definitions for the CCD acquisition sequencer.
//   state_t        : sequencer FSM states
//   PX_TOTAL       : last pixel index produced by the CCD timing generator
//   PIX_FIRST_DEF  : default first effective pixel (inclusive)
//   PIX_LAST_DEF   : default last effective pixel (inclusive)
//   max_int()      : helper for sizing counters from parameters
package ccd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    READ  = 3'd2,
    GAP   = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam int PX_TOTAL      = 5474;
  localparam int PIX_FIRST_DEF = 64;
  localparam int PIX_LAST_DEF  = 5403;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ccd_tick_timer.sv
// Loadable down-counter with a zero flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over enable)
//   load_val   : value to load
//   en         : decrement by one while nonzero
//   zero       : count is zero
// The sequencer shares one instance between the integration gap (shoot low)
// and the frame timeout (shoot high); the two uses never overlap in time.
module ccd_tick_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/ccd_acq_sequencer.sv
// CCD acquisition sequencer: runs the timing generator for a programmed
// number of frames, inserts integration gaps between frames, optionally
// discards a flush frame, gates effective pixels and guards against a stalled
// timing generator with a timeout.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : acquisition request (IDLE only)
//   abort        : stop request (any non-IDLE state)
//   frames       : kept frames per acquisition, 0 = continuous
//   exp_ticks    : integration gap length in clk cycles
//   flush_en     : discard the first frame of the acquisition
//   frame_done   : end-of-frame flag from the timing generator
//   pxcount      : current pixel index from the timing generator
//   shoot        : run-enable to the timing generator
//   busy         : sequencer not IDLE
//   pix_valid    : effective-pixel gate (one cycle behind pxcount)
//   sof, eof     : start / end of kept frame pulses
//   frame_idx    : kept-frame counter
//   done         : acquisition finished pulse
//   err_timeout  : sticky timeout flag, cleared on the next accepted start
module ccd_acq_sequencer
  import ccd_pkg::*;
#(
  parameter int EXP_W     = 24,
  parameter int PIX_FIRST = PIX_FIRST_DEF,
  parameter int PIX_LAST  = PIX_LAST_DEF,
  parameter int TIMEOUT   = 2 ** 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       frames,
  input  logic [EXP_W-1:0] exp_ticks,
  input  logic             flush_en,
  input  logic             frame_done,
  input  logic [12:0]      pxcount,
  output logic             shoot,
  output logic             busy,
  output logic             pix_valid,
  output logic             sof,
  output logic             eof,
  output logic [7:0]       frame_idx,
  output logic             done,
  output logic             err_timeout
);

  // Counter must hold both the gap length and TIMEOUT-1.
  localparam int CNT_W = max_int(EXP_W, $clog2(TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT - 1);
  localparam logic [12:0] PIX_LO = 13'(PIX_FIRST);
  localparam logic [12:0] PIX_HI = 13'(PIX_LAST);

  state_t           state_reg;
  logic [7:0]       frames_reg;
  logic [EXP_W-1:0] exp_reg;
  logic [7:0]       kept_reg;
  logic             fd_reg;
  logic             shoot_reg;
  logic             busy_reg;
  logic             pix_valid_reg;
  logic             sof_reg;
  logic             eof_reg;
  logic             done_reg;
  logic             err_reg;

  logic             fd_edge;
  logic [7:0]       kept_next;
  logic [CNT_W-1:0] gap_load;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_zero;

  // Only edges seen while the generator is enabled belong to a frame.
  assign fd_edge   = frame_done & ~fd_reg & shoot_reg;
  assign kept_next = kept_reg + 8'd1;

  // Timer counts down to zero after load, so a gap of N cycles loads N-1;
  // exp_ticks = 0 still yields a single gap cycle.
  assign gap_load = (exp_reg == '0) ? '0 : CNT_W'(exp_reg - 1'b1);

  // Timer schedule: reload the timeout on every shoot rise, load the gap on
  // every frame_done edge (which always ends the shoot-high period).
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TO_LOAD;
    tmr_en   = 1'b0;
    case (state_reg)
      IDLE: tmr_load = start;
      FLUSH, READ: begin
        tmr_en = 1'b1;
        if (fd_edge) begin
          tmr_load = 1'b1;
          tmr_val  = gap_load;
        end
      end
      GAP: begin
        tmr_en   = 1'b1;
        tmr_load = tmr_zero;
      end
      default: ;
    endcase
  end

  ccd_tick_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      frames_reg    <= '0;
      exp_reg       <= '0;
      kept_reg      <= '0;
      fd_reg        <= 1'b0;
      shoot_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      pix_valid_reg <= 1'b0;
      sof_reg       <= 1'b0;
      eof_reg       <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      fd_reg        <= frame_done;
      sof_reg       <= 1'b0;
      eof_reg       <= 1'b0;
      done_reg      <= 1'b0;
      pix_valid_reg <= (state_reg == READ) && (pxcount >= PIX_LO) && (pxcount <= PIX_HI);

      case (state_reg)
        IDLE: begin
          if (start) begin
            frames_reg <= frames;
            exp_reg    <= exp_ticks;
            kept_reg   <= '0;
            err_reg    <= 1'b0;
            shoot_reg  <= 1'b1;
            busy_reg   <= 1'b1;
            if (flush_en) begin
              state_reg <= FLUSH;
            end else begin
              state_reg <= READ;
              sof_reg   <= 1'b1;
            end
          end
        end

        FLUSH, READ: begin
          // abort beats a coincident frame edge, so a partial frame never
          // produces eof.
          if (abort) begin
            shoot_reg <= 1'b0;
            state_reg <= STOP;
          end else if (fd_edge) begin
            shoot_reg <= 1'b0;
            if (state_reg == READ) begin
              eof_reg  <= 1'b1;
              kept_reg <= kept_next;
              if ((frames_reg != 8'd0) && (kept_next == frames_reg)) begin
                state_reg <= STOP;
              end else begin
                state_reg <= GAP;
              end
            end else begin
              state_reg <= GAP;
            end
          end else if (tmr_zero) begin
            err_reg   <= 1'b1;
            shoot_reg <= 1'b0;
            state_reg <= STOP;
          end
        end

        GAP: begin
          if (abort) begin
            state_reg <= STOP;
          end else if (tmr_zero) begin
            shoot_reg <= 1'b1;
            sof_reg   <= 1'b1;
            state_reg <= READ;
          end
        end

        STOP: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign shoot       = shoot_reg;
  assign busy        = busy_reg;
  assign pix_valid   = pix_valid_reg;
  assign sof         = sof_reg;
  assign eof         = eof_reg;
  assign frame_idx   = kept_reg;
  assign done        = done_reg;
  assign err_timeout = err_reg;

endmodule
